modulo: RTL and testbench
=========================

Name: modulo

Overview:
- Sequential unsigned modulo unit: computes dividend mod divisor, with a SIZE-bit dividend and a SIZE/2-bit divisor.
- Uses restoring shift-subtract, one dividend bit per clock.
- Sits in the ElGamal datapath as the reduction stage after products are formed.
- AXI-Stream-style valid/ready on two input channels and one output channel.

Parameters:
- SIZE, 128, dividend width in bits; must be even and at least 4. Divisor and result are SIZE/2 bits.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  reset, asynchronous and active-low (0 = reset).
- input_dividen_tdata  input  SIZE  unsigned dividend.
- input_dividen_tvalid  input  1  dividend valid.
- input_dividen_tready  output  1  dividend accepted.
- input_divisor_tdata  input  SIZE/2  unsigned divisor.
- input_divisor_tvalid  input  1  divisor valid.
- input_divisor_tready  output  1  divisor accepted.
- output_tdata  output  SIZE/2  remainder.
- output_tvalid  output  1  remainder valid.
- output_tready  input  1  downstream accepts remainder.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; output_tdata=0; output_tvalid=0; both tready=0; internal registers cleared. Reset mid-operation aborts the computation; nothing is emitted.
- States: IDLE, BUSY, DONE.
- IDLE:
  - input_dividen_tready = input_divisor_tready = (both tvalid high), combinational from state and valids.
  - Transfer occurs only when both tvalid are high, consuming both operands on the same edge.
  - A single valid operand is not consumed.
  - On transfer: latch dividend into shift register D and divisor into V; clear partial remainder R (SIZE/2+1 bits); counter=SIZE; go to BUSY.
  - If V==0 at transfer: go directly to DONE with output_tdata = all ones (defined result for divide-by-zero).
- BUSY, each cycle:
  - T = {R[SIZE/2-1:0], D[SIZE-1]}; D shifts left by 1.
  - If T >= {1'b0,V} then R = T - V, else R = T.
  - Counter decrements.
  - On the SIZE-th BUSY cycle: register the final R[SIZE/2-1:0] into output_tdata, set output_tvalid=1, go to DONE.
- Latency: output_tvalid is high after exactly SIZE rising edges following the input-transfer edge (divisor 0: 1 edge).
- DONE:
  - output_tvalid held high and output_tdata held stable until output_tready=1 on a rising edge.
  - On that edge: output_tvalid=0, go to IDLE.
  - Inputs are not accepted in the same cycle as the output transfer; a new transfer is possible the following cycle.
- Result is always less than the divisor, so SIZE/2 bits suffice.
- Inputs are ignored while BUSY or DONE (tready=0).

Optional Feature:
- Macro MODULO_BYPASS_EN.
- Defined: in IDLE, if dividend < zero-extended divisor at transfer, skip BUSY. Go directly to DONE with output_tdata = dividend[SIZE/2-1:0] (latency 1 edge).
- Not defined: every nonzero-divisor operation takes SIZE cycles, regardless of value.

Test Plan:
- SIZE=128, rst released, dividend=1000, divisor=37, output_tready=1 -> output_tdata=1, output_tvalid after 128 edges, pulse 1 cycle; with inputs still valid, a new transfer occurs the next cycle.
- dividend=2^128-1, divisor=2^64-1 -> 0; dividend=100, divisor=7 -> 2.
- dividend=5, divisor=9 -> 5 (128 cycles without macro, 1 cycle with MODULO_BYPASS_EN).
- divisor=0, dividend=12345 -> output_tdata=64'hFFFF_FFFF_FFFF_FFFF after 1 edge.
- Backpressure: output_tready=0 for 10 cycles after valid -> tvalid and tdata held stable, both input treadys low; then tready=1 -> single transfer, back to IDLE.
- Only dividend valid for 5 cycles -> both tready stay 0, no computation. Assert rst=0 in mid-BUSY -> all outputs 0 immediately, no result emitted after release.

Source files
------------

// File: rtl/modulo.sv
// Sequential unsigned modulo (restoring shift-subtract, one dividend bit per clock).
// Define MODULO_BYPASS_EN to return small dividends (dividend < divisor) without iterating.
module modulo #(
  parameter int SIZE = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [SIZE-1:0]   input_dividen_tdata,
  input  logic              input_dividen_tvalid,
  output logic              input_dividen_tready,
  input  logic [SIZE/2-1:0] input_divisor_tdata,
  input  logic              input_divisor_tvalid,
  output logic              input_divisor_tready,
  output logic [SIZE/2-1:0] output_tdata,
  output logic              output_tvalid,
  input  logic              output_tready
);

  localparam int H  = SIZE / 2;
  localparam int CW = $clog2(SIZE + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state_q, state_d;
  logic [SIZE-1:0] d_q, d_d;
  logic [H-1:0]    v_q, v_d;
  logic [H:0]      r_q, r_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [H-1:0]    out_q, out_d;
  logic            vld_q, vld_d;

  logic            xfer;
  logic [H:0]      t;
  logic [H:0]      t_sub;
  logic [H:0]      r_next;

  // Both operands are consumed together; rst gating keeps tready low while in reset.
  assign xfer = rst && (state_q == IDLE) && input_dividen_tvalid && input_divisor_tvalid;

  assign input_dividen_tready = xfer;
  assign input_divisor_tready = xfer;
  assign output_tdata         = out_q;
  assign output_tvalid        = vld_q;

  assign t      = {r_q[H-1:0], d_q[SIZE-1]};
  assign t_sub  = t - {1'b0, v_q};
  assign r_next = (t >= {1'b0, v_q}) ? t_sub : t;

  always_comb begin
    state_d = state_q;
    d_d     = d_q;
    v_d     = v_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    vld_d   = vld_q;
    case (state_q)
      IDLE: begin
        if (xfer) begin
          d_d   = input_dividen_tdata;
          v_d   = input_divisor_tdata;
          r_d   = '0;
          cnt_d = CW'(SIZE);
          if (input_divisor_tdata == '0) begin
            out_d   = '1;
            vld_d   = 1'b1;
            state_d = DONE;
          end
`ifdef MODULO_BYPASS_EN
          else if (input_dividen_tdata < {{H{1'b0}}, input_divisor_tdata}) begin
            out_d   = input_dividen_tdata[H-1:0];
            vld_d   = 1'b1;
            state_d = DONE;
          end
`endif
          else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        d_d   = {d_q[SIZE-2:0], 1'b0};
        r_d   = r_next;
        cnt_d = cnt_q - CW'(1);
        // Last bit: the remainder is below the divisor, so the low H bits are exact.
        if (cnt_q == CW'(1)) begin
          out_d   = r_next[H-1:0];
          vld_d   = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (output_tready) begin
          vld_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        vld_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      d_q     <= '0;
      v_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      d_q     <= d_d;
      v_q     <= v_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      vld_q   <= vld_d;
    end
  end

endmodule

// File: tb/tb_modulo.sv
// Scoreboard bench for modulo: expected remainders are queued at input transfer and popped at output.
module tb_modulo;

  localparam int SIZE = 128;
  localparam int H    = SIZE / 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [SIZE-1:0] input_dividen_tdata;
  logic            input_dividen_tvalid;
  logic            input_dividen_tready;
  logic [H-1:0]    input_divisor_tdata;
  logic            input_divisor_tvalid;
  logic            input_divisor_tready;
  logic [H-1:0]    output_tdata;
  logic            output_tvalid;
  logic            output_tready;

  int checks = 0;
  int errors = 0;
  logic [H-1:0] sb_q[$];

  modulo #(.SIZE(SIZE)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .input_dividen_tdata  (input_dividen_tdata),
    .input_dividen_tvalid (input_dividen_tvalid),
    .input_dividen_tready (input_dividen_tready),
    .input_divisor_tdata  (input_divisor_tdata),
    .input_divisor_tvalid (input_divisor_tvalid),
    .input_divisor_tready (input_divisor_tready),
    .output_tdata         (output_tdata),
    .output_tvalid        (output_tvalid),
    .output_tready        (output_tready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [SIZE-1:0] obs, input logic [SIZE-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [H-1:0] mod_model(input logic [SIZE-1:0] a, input logic [H-1:0] b);
    logic [SIZE-1:0] r;
    if (b == '0) return '1;
    r = a % {{H{1'b0}}, b};
    return r[H-1:0];
  endfunction

  // Edges after the transfer edge until tvalid; 0 means valid set by the transfer edge itself.
  function automatic int lat_model(input logic [SIZE-1:0] a, input logic [H-1:0] b);
    if (b == '0) return 0;
`ifdef MODULO_BYPASS_EN
    if (a < {{H{1'b0}}, b}) return 0;
`endif
    return SIZE;
  endfunction

  function automatic logic [SIZE-1:0] rdys();
    return SIZE'({input_dividen_tready, input_divisor_tready});
  endfunction

  // Called between edges; returns just after the transfer edge with valids still high.
  task automatic xfer(input logic [SIZE-1:0] a, input logic [H-1:0] b);
    input_dividen_tdata  = a;
    input_divisor_tdata  = b;
    input_dividen_tvalid = 1'b1;
    input_divisor_tvalid = 1'b1;
    #1;
    chk("in_rdy", rdys(), SIZE'(2'b11));
    sb_q.push_back(mod_model(a, b));
    @(posedge clk);
    #1;
  endtask

  task automatic wait_out(input int exp_lat);
    int lat;
    lat = 0;
    while (!output_tvalid && lat < 300) begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == 1 && !output_tvalid) chk("busy_rdy", rdys(), '0);
    end
    chk("lat", SIZE'(lat), SIZE'(exp_lat));
    chk("sb_size", SIZE'(sb_q.size()), SIZE'(1));
    if (sb_q.size() > 0) chk("data", SIZE'(output_tdata), SIZE'(sb_q.pop_front()));
  endtask

  task automatic run(input logic [SIZE-1:0] a, input logic [H-1:0] b);
    xfer(a, b);
    input_dividen_tvalid = 1'b0;
    input_divisor_tvalid = 1'b0;
    wait_out(lat_model(a, b));
    @(posedge clk);
    #1;
    chk("ack", SIZE'(output_tvalid), '0);
  endtask

  initial begin
    int seen;
    logic [SIZE-1:0] ra;
    logic [H-1:0]    rb;
    rst                  = 1'b0;
    input_dividen_tdata  = '0;
    input_divisor_tdata  = '0;
    input_dividen_tvalid = 1'b0;
    input_divisor_tvalid = 1'b0;
    output_tready        = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    input_dividen_tvalid = 1'b1;
    input_divisor_tvalid = 1'b1;
    #1;
    chk("rst_rdy", rdys(), '0);
    chk("rst_vld", SIZE'(output_tvalid), '0);
    chk("rst_data", SIZE'(output_tdata), '0);
    input_dividen_tvalid = 1'b0;
    input_divisor_tvalid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Back-to-back: inputs stay valid through the whole first operation.
    output_tready = 1'b1;
    xfer(SIZE'(1000), H'(37));
    wait_out(lat_model(SIZE'(1000), H'(37)));
    @(posedge clk);
    #1;
    chk("pulse", SIZE'(output_tvalid), '0);
    xfer(SIZE'(1000), H'(37));
    input_dividen_tvalid = 1'b0;
    input_divisor_tvalid = 1'b0;
    wait_out(lat_model(SIZE'(1000), H'(37)));
    @(posedge clk);
    #1;
    chk("pulse2", SIZE'(output_tvalid), '0);

    run('1, '1);
    run(SIZE'(100), H'(7));
    run(SIZE'(5), H'(9));
    run(SIZE'(12345), '0);
    for (int i = 0; i < 4; i++) begin
      ra = {$urandom, $urandom, $urandom, $urandom};
      rb = {$urandom, $urandom};
      run(ra, rb);
    end

    // Backpressure with input valids held high the whole time.
    output_tready = 1'b0;
    xfer(SIZE'(999999), H'(1000));
    wait_out(lat_model(SIZE'(999999), H'(1000)));
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk("bp_vld", SIZE'(output_tvalid), SIZE'(1));
      chk("bp_data", SIZE'(output_tdata), SIZE'(999));
      chk("bp_rdy", rdys(), '0);
    end
    output_tready = 1'b1;
    @(posedge clk);
    #1;
    input_dividen_tvalid = 1'b0;
    input_divisor_tvalid = 1'b0;
    chk("bp_ack", SIZE'(output_tvalid), '0);
    @(posedge clk);
    #1;
    chk("bp_idle", SIZE'(output_tvalid), '0);

    input_dividen_tdata  = SIZE'(77);
    input_dividen_tvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("one_rdy", rdys(), '0);
      chk("one_vld", SIZE'(output_tvalid), '0);
    end
    input_dividen_tvalid = 1'b0;

    // Abort in the middle of an operation.
    xfer(SIZE'(1000), H'(37));
    input_dividen_tvalid = 1'b0;
    input_divisor_tvalid = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    input_dividen_tvalid = 1'b1;
    input_divisor_tvalid = 1'b1;
    rst = 1'b0;
    #1;
    chk("mid_vld", SIZE'(output_tvalid), '0);
    chk("mid_data", SIZE'(output_tdata), '0);
    chk("mid_rdy", rdys(), '0);
    sb_q.delete();
    input_dividen_tvalid = 1'b0;
    input_divisor_tvalid = 1'b0;
    @(posedge clk);
    #1;
    rst  = 1'b1;
    seen = 0;
    repeat (200) begin
      @(posedge clk);
      #1;
      if (output_tvalid) seen++;
    end
    chk("no_emit", SIZE'(seen), '0);

    run(SIZE'(100), H'(7));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
